// File: rtl/q15_multiplier.sv
// Signed Q15 64x64 multiplier: one radix-2 shift-add step per cycle on operand magnitudes,
// then sign fix-up, floor shift by 15 and saturation to 64 bits.
module q15_multiplier (
  input  logic        clk,
  input  logic        reset,
  input  logic        launch,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [63:0] res
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t       state;
  logic [5:0]   cnt;
  logic         sign;
  logic [127:0] mcand;
  logic [63:0]  mplier;
  logic [127:0] acc;

  logic [63:0]  mag_a;
  logic [63:0]  mag_b;
  logic [64:0]  fin;

  // Negating -2^63 in 64 bits yields 2^63 read as unsigned, so no widening is needed.
  assign mag_a = a[63] ? (~a + 64'd1) : a;
  assign mag_b = b[63] ? (~b + 64'd1) : b;

  // Returns {ovf, res}: signed product, arithmetic shift right by 15, then range check.
  function automatic logic [64:0] q15_finish(input logic [127:0] mag, input logic neg);
    logic [127:0] prod;
    logic         fits;
    prod = neg ? (~mag + 128'd1) : mag;
    fits = (&prod[127:78]) | ~(|prod[127:78]);
    if (fits)
      q15_finish = {1'b0, prod[78:15]};
    else if (prod[127])
      q15_finish = {1'b1, 64'h8000_0000_0000_0000};
    else
      q15_finish = {1'b1, 64'h7FFF_FFFF_FFFF_FFFF};
  endfunction

  assign fin = q15_finish(acc, sign);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      sign   <= 1'b0;
      mcand  <= 128'd0;
      mplier <= 64'd0;
      acc    <= 128'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
      res    <= 64'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            sign   <= a[63] ^ b[63];
            mcand  <= {64'd0, mag_a};
            mplier <= mag_b;
            acc    <= 128'd0;
            cnt    <= 6'd0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
          if (cnt == 6'd63)
            state <= FINAL;
        end
        FINAL: begin
          ovf   <= fin[64];
          res   <= fin[63:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_q15_multiplier.sv
// Scoreboard bench for q15_multiplier: stimulus pushes hand-computed results,
// a monitor pops and checks them on every done pulse along with latency and busy length.
module tb_q15_multiplier;

  logic        clk;
  logic        reset;
  logic        launch;
  logic [63:0] a;
  logic [63:0] b;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [63:0] res;

  q15_multiplier dut (
    .clk    (clk),
    .reset  (reset),
    .launch (launch),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .res    (res)
  );

  typedef struct {
    logic [63:0] res;
    logic        ovf;
    int          cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   busy_run = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on each done pulse; also checks busy held exactly 65 cycles.
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      busy_run++;
    end else begin
      if (reset === 1'b1 && done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, expected no result pending", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, "_res"}, res, e.res);
          check({e.name, "_ovf"}, {63'd0, ovf}, {63'd0, e.ovf});
          check({e.name, "_latency"}, 64'(cyc - e.cyc), 64'd65);
          check({e.name, "_busy_len"}, 64'(busy_run), 64'd65);
        end
      end
      busy_run = 0;
    end
  end

  // Called at a negedge; returns at the negedge after acceptance with operands scrambled.
  task automatic issue(input logic [63:0] va, input logic [63:0] vb, input logic [63:0] er,
                       input logic eo, input bit push, input string name);
    exp_t e;
    a = va;
    b = vb;
    launch = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      e.res = er;
      e.ovf = eo;
      e.cyc = cyc;
      e.name = name;
      exp_q.push_back(e);
    end
    @(negedge clk);
    launch = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: done not seen within 100 cycles, expected done at 65", name);
    end
  endtask

  task automatic run_op(input logic [63:0] va, input logic [63:0] vb, input logic [63:0] er,
                        input logic eo, input string name);
    issue(va, vb, er, eo, 1'b1, name);
    wait_done(name);
  endtask

  initial begin
    reset  = 1'b0;
    launch = 1'b1;
    a      = 64'h8000;
    b      = 64'h8000;
    repeat (3) @(negedge clk);
    // launch held high during reset must be ignored
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_ovf", {63'd0, ovf}, 64'd0);
    check("reset_res", res, 64'd0);
    launch = 1'b0;
    reset  = 1'b1;
    @(negedge clk);

    run_op(64'h8000, 64'h8000, 64'h8000, 1'b0, "one_x_one");
    run_op(64'hFFFF_FFFF_FFFF_4000, 64'h1_0000, 64'hFFFF_FFFF_FFFE_8000, 1'b0, "m1p5_x_2");
    run_op(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "tiny_neg_floor");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "neg_half_lsb");
    run_op(64'd1, 64'h4000, 64'd0, 1'b0, "pos_half_lsb");
    run_op(64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, "sat_pos");
    run_op(64'h4000_0000_0000_0000, 64'hC000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, "sat_neg");
    run_op(64'h8000_0000_0000_0000, 64'h8000, 64'h8000_0000_0000_0000, 1'b0, "minint_x_one");
    run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, "minint_x_m1");
    run_op(64'd0, 64'h1234_5678, 64'd0, 1'b0, "zero_operand");

    // Second launch mid-operation must be ignored
    issue(64'd3, 64'h8000, 64'd3, 1'b0, 1'b1, "launch_busy");
    repeat (8) @(negedge clk);
    a = 64'd7;
    b = 64'h8000;
    launch = 1'b1;
    @(negedge clk);
    launch = 1'b0;
    wait_done("launch_busy");

    // Launch in the done cycle: back-to-back
    run_op(64'h8000, 64'h8000, 64'h8000, 1'b0, "b2b_first");
    run_op(64'h8000, 64'h8000, 64'h8000, 1'b0, "b2b_second");

    // Reset mid-run aborts with no done
    issue(64'h8000, 64'h8000, 64'd0, 1'b0, 1'b0, "abort");
    repeat (29) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_res", res, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_res_after", res, 64'd0);
    check("abort_busy_after", {63'd0, busy}, 64'd0);

    run_op(64'h1_8000, 64'h8000, 64'h1_8000, 1'b0, "after_abort");

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/q15_multiplier.md
Q15_MULTIPLIER -- requirements
Module: q15_multiplier

Interface
REQ-001 The block SHALL have no parameters: 64-bit operands and 15 fractional bits, where value = integer / 2^15, are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 launch  input  1  start request; sampled on a rising edge while IDLE.
REQ-005 a  input  64  signed Q15 multiplicand; captured on launch acceptance.
REQ-006 b  input  64  signed Q15 multiplier; captured on launch acceptance.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  one-cycle pulse when res/ovf become valid.
REQ-009 ovf  output  1  result saturated; valid with done, held until next done.
REQ-010 res  output  64  signed Q15 product; held until next done.

Function
REQ-011 States SHALL be IDLE, RUN and FINAL, with a 6-bit iteration counter.
REQ-012 In IDLE with launch=1 at edge k, the block SHALL capture a and b, record sign = a[63]^b[63], load |a| and |b| as 64-bit unsigned magnitudes, clear the 128-bit accumulator and counter, and enter RUN; busy=1 from edge k.
REQ-013 The magnitude of -2^63 SHALL be 2^63 unsigned, with no wrap.
REQ-014 Each RUN cycle SHALL perform one radix-2 shift-add step (one multiplier bit); after 64 steps (edge k+64) the state SHALL become FINAL.
REQ-015 FINAL SHALL form the 128-bit two's-complement product P (the magnitude product negated if sign=1), then R = P arithmetic-shift-right 15, which is floor rounding toward -inf, not toward zero.
REQ-016 If P[127:78] is not all equal to P[78], res SHALL saturate to 0x7FFF_FFFF_FFFF_FFFF (P positive) or 0x8000_0000_0000_0000 (P negative) with ovf=1; otherwise res = R[63:0] and ovf=0.
REQ-017 At edge k+65 the block SHALL register res and ovf, pulse done=1 for exactly one cycle, drop busy to 0 and return to IDLE; busy is high for exactly 65 cycles and launch-to-done latency is 65 cycles.
REQ-018 launch while busy=1 SHALL be ignored, with no effect on the operation in progress or on captured operands.
REQ-019 launch=1 in the cycle done=1 SHALL be accepted, since the state is IDLE; back-to-back throughput SHALL be one result per 65 cycles.
REQ-020 Changes on a/b after acceptance SHALL NOT affect the result.
REQ-021 A zero operand SHALL still take the full 65 cycles, with res=0 and ovf=0; there is no early termination.

Reset
REQ-022 reset=0 SHALL immediately, without waiting for clk, force state=IDLE, busy=0, done=0, ovf=0, res=0, and clear the counter and accumulator.
REQ-023 Reset during RUN or FINAL SHALL abort the operation; no done pulse SHALL follow, and res SHALL remain 0.
REQ-024 launch SHALL be ignored while reset=0; the first accepted launch is at the first rising edge with reset=1.

Verification
REQ-025 a=0x8000 (1.0), b=0x8000 -> done after 65 cycles; res=0x0000_0000_0000_8000, ovf=0.
REQ-026 a=0xFFFF_FFFF_FFFF_4000 (-1.5), b=0x1_0000 (2.0) -> res=0xFFFF_FFFF_FFFE_8000 (-3.0), ovf=0; a=1, b=-1 -> res=0xFFFF_FFFF_FFFF_FFFF (floor of -2^-30).
REQ-027 a=b=0x4000_0000_0000_0000 -> res=0x7FFF_FFFF_FFFF_FFFF, ovf=1; a=0x4000_0000_0000_0000, b=-0x4000_0000_0000_0000 -> res=0x8000_0000_0000_0000, ovf=1.
REQ-028 launch a=3, b=0x8000, then launch again at cycle +10 with a=7 -> single done at cycle 65, res=3; busy continuous for 65 cycles.
REQ-029 Reset pulsed at cycle 30 of an operation -> busy=0 immediately, no done, res=0; a new launch afterwards completes normally in 65 cycles.
REQ-030 launch asserted in the done cycle with a=b=0x8000 -> second done exactly 65 cycles later, res=0x8000.
